// File: rtl/lfsr_pkg.sv
// Shared types, constants and the LFSR step function for the stream-cipher decryptor.
// The same lfsr_next() is used by the CPU reference model, so keep it bit-exact.
package lfsr_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      S_TAP,
      S_RD,
      S_WR,
      S_PAD,
      S_DONE
   } dec_state_t;

   localparam byte_t SPACE_CHAR = 8'h20;

   // XNOR feedback: the software encoder's parity accumulator starts at 1.
   function automatic byte_t lfsr_next(byte_t s, byte_t tap);
      return {s[6:0], ~^(s & tap)};
   endfunction

endpackage

// File: rtl/lfsr_decrypter_if.sv
// Control handshake and 8-bit data-memory port of the LFSR decryptor.
// master = decryptor side, slave = CPU/memory side.
interface lfsr_decrypter_if;
   import lfsr_pkg::*;

   logic       start;
   logic       busy;
   logic       done;
   byte_t      mem_addr;
   logic       mem_wen;
   byte_t      mem_wdata;
   byte_t      mem_rdata;
   logic [6:0] lead_cnt;
   logic       err;

   modport master (
      input  start, mem_rdata,
      output busy, done, mem_addr, mem_wen, mem_wdata, lead_cnt, err
   );

   modport slave (
      output start, mem_rdata,
      input  busy, done, mem_addr, mem_wen, mem_wdata, lead_cnt, err
   );

endinterface

// File: rtl/lfsr_step.sv
// One keystream step: picks the key (seed recovery on byte 0), decrypts the byte
// and computes the next LFSR state.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter byte_t SPACE = SPACE_CHAR
) (
   input  logic  first,
   input  byte_t rdata,
   input  byte_t state,
   input  byte_t tap,
   output byte_t key,
   output byte_t plain,
   output byte_t state_next
);

   // Byte 0 always encrypts a space, so the seed falls out of the ciphertext.
   assign key        = first ? (rdata ^ SPACE) : state;
   assign plain      = rdata ^ key;
   assign state_next = lfsr_next(key, tap);

endmodule

// File: rtl/lfsr_decrypter.sv
// LFSR stream-cipher decryptor: reads the encrypted block, strips leading spaces,
// writes plaintext tail-padded with spaces. Optional macro: LFSR_DEC_ASCII_CHECK_EN.
module lfsr_decrypter
   import lfsr_pkg::*;
#(
   parameter byte_t ENC_BASE = 8'd64,
   parameter byte_t DEC_BASE = 8'd128,
   parameter byte_t TAP_ADDR = 8'd62,
   parameter int    MSG_LEN  = 64,
   parameter byte_t SPACE    = SPACE_CHAR
) (
   input  logic                clk,
   input  logic                reset,
   lfsr_decrypter_if.master    bus
);

   localparam byte_t LEN_B  = byte_t'(MSG_LEN);
   localparam byte_t LAST_B = byte_t'(MSG_LEN - 1);

   dec_state_t fsm_reg, fsm_next;
   byte_t      lfsr_reg;
   byte_t      tap_reg;
   byte_t      i_reg;
   byte_t      wptr_reg;
   logic       leading_reg;
   logic [6:0] lead_cnt_reg;

   byte_t key, plain, state_next;
   logic  wr_byte;
   byte_t wptr_inc;

   byte_t addr_c, wdata_c;
   logic  wen_c;

   lfsr_step #(.SPACE(SPACE)) u_step (
      .first      (i_reg == 8'd0),
      .rdata      (bus.mem_rdata),
      .state      (lfsr_reg),
      .tap        (tap_reg),
      .key        (key),
      .plain      (plain),
      .state_next (state_next)
   );

   assign wr_byte  = (fsm_reg == S_WR) && !(leading_reg && plain == SPACE);
   assign wptr_inc = wptr_reg + (wr_byte ? 8'd1 : 8'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fsm_reg <= IDLE;
      else       fsm_reg <= fsm_next;
   end

   always_comb begin
      fsm_next = fsm_reg;
      case (fsm_reg)
         IDLE:   if (bus.start) fsm_next = S_TAP;
         S_TAP:  fsm_next = S_RD;
         S_RD:   fsm_next = S_WR;
         S_WR: begin
            if (i_reg == LAST_B) fsm_next = (wptr_inc < LEN_B) ? S_PAD : S_DONE;
            else                 fsm_next = S_RD;
         end
         S_PAD:  if (wptr_reg == LAST_B) fsm_next = S_DONE;
         S_DONE: fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   always_comb begin
      addr_c  = 8'd0;
      wdata_c = 8'd0;
      wen_c   = 1'b0;
      case (fsm_reg)
         S_TAP: addr_c = TAP_ADDR;
         S_RD:  addr_c = ENC_BASE + i_reg;
         S_WR: begin
            addr_c  = DEC_BASE + wptr_reg;
            wdata_c = plain;
            wen_c   = wr_byte;
         end
         S_PAD: begin
            addr_c  = DEC_BASE + wptr_reg;
            wdata_c = SPACE;
            wen_c   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy      = (fsm_reg != IDLE);
   assign bus.done      = (fsm_reg == S_DONE);
   assign bus.mem_addr  = addr_c;
   assign bus.mem_wdata = wdata_c;
   assign bus.mem_wen   = wen_c;
   assign bus.lead_cnt  = lead_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_reg     <= 8'd0;
         tap_reg      <= 8'd0;
         i_reg        <= 8'd0;
         wptr_reg     <= 8'd0;
         leading_reg  <= 1'b1;
         lead_cnt_reg <= 7'd0;
      end else begin
         case (fsm_reg)
            IDLE: if (bus.start) begin
               i_reg        <= 8'd0;
               wptr_reg     <= 8'd0;
               leading_reg  <= 1'b1;
               lead_cnt_reg <= 7'd0;
            end
            // Read data here is the tap byte addressed in S_TAP.
            S_RD: if (i_reg == 8'd0) tap_reg <= bus.mem_rdata;
            S_WR: begin
               lfsr_reg <= state_next;
               i_reg    <= i_reg + 8'd1;
               wptr_reg <= wptr_inc;
               if (wr_byte) leading_reg  <= 1'b0;
               else         lead_cnt_reg <= lead_cnt_reg + 7'd1;
            end
            S_PAD: wptr_reg <= wptr_reg + 8'd1;
            default: ;
         endcase
      end
   end

`ifdef LFSR_DEC_ASCII_CHECK_EN
   logic err_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             err_reg <= 1'b0;
      else if (fsm_reg == IDLE && bus.start) err_reg <= 1'b0;
      else if (wr_byte && (plain[7] || plain < SPACE_CHAR)) err_reg <= 1'b1;
   end

   assign bus.err = err_reg;
`else
   assign bus.err = 1'b0;
`endif

endmodule
